// File: rtl/uart_tx_serial_if.sv
// ============================================================================
//  Module   : uart_tx_serial_if
//  Brief    : Parallel-side handshake and serial-line bundle for uart_tx_serial.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_serial_if;
    logic [7:0] DATA_IN;
    logic       LOAD;
    logic       READY;
    logic       CTS;
    logic       TX;
    logic       BUSY;
    logic       TX_DONE;

    modport master (
        output DATA_IN, LOAD, CTS,
        input  READY, TX, BUSY, TX_DONE
    );

    modport slave (
        input  DATA_IN, LOAD, CTS,
        output READY, TX, BUSY, TX_DONE
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serial.sv
// ============================================================================
//  Module   : uart_tx_serial
//  Brief    : MSB-first UART transmitter with mode-selected baud/parity/stop.
//             Optional macro UART_TX_CTS_EN enables CTS gating of frame start.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_serial #(
    parameter logic [7:0] MODOS = 8'b10110101
) (
    input  wire logic         Clock,
    input  wire logic         Reset_n,
    uart_tx_serial_if.slave   bus
);

    localparam logic [13:0] c_DIV = (MODOS[7:6] == 2'b00) ? 14'd10416 :
                                    (MODOS[7:6] == 2'b01) ? 14'd5208  :
                                    (MODOS[7:6] == 2'b10) ? 14'd2604  :
                                                            14'd868;
    localparam logic [13:0] c_LAST = c_DIV - 14'd1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CTS = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_PARIDADE = 3'd4,
        S_STOP1    = 3'd5,
        S_STOP2    = 3'd6
    } state_t;

    state_t      r_state;
    logic [13:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        w_cts_ok;
    logic        w_bit_end;

`ifdef UART_TX_CTS_EN
    logic r_cts_s1;
    logic r_cts_s2;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cts_s1 <= 1'b0;
            r_cts_s2 <= 1'b0;
        end else begin
            r_cts_s1 <= bus.CTS;
            r_cts_s2 <= r_cts_s1;
        end
    end

    assign w_cts_ok = r_cts_s2;
`else
    logic w_unused_cts;
    assign w_unused_cts = bus.CTS;
    assign w_cts_ok     = 1'b1;
`endif

    assign w_bit_end = (r_cnt == c_LAST);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 14'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 14'd0;
                    if (bus.LOAD) begin
                        r_shift <= bus.DATA_IN;
                        r_par   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_CTS;
                    end
                end
                S_WAIT_CTS: begin
                    r_cnt <= 14'd0;
                    if (w_cts_ok) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= 14'd0;
                        r_bit_idx <= 3'd7;
                        r_tx      <= r_shift[7];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= 14'd0;
                        r_par   <= r_par ^ r_shift[7];
                        r_shift <= {r_shift[6:0], 1'b0};
                        if (r_bit_idx == 3'd0) begin
                            // Parity folds in the bit just finished, not yet in r_par.
                            if (MODOS[0]) begin
                                r_tx    <= r_par ^ r_shift[7] ^ MODOS[1];
                                r_state <= S_PARIDADE;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 3'd1;
                            r_tx      <= r_shift[6];
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                S_PARIDADE: begin
                    if (w_bit_end) begin
                        r_cnt   <= 14'd0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP1;
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                S_STOP1: begin
                    if (w_bit_end) begin
                        r_cnt <= 14'd0;
                        if (MODOS[5]) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_STOP2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                S_STOP2: begin
                    if (w_bit_end) begin
                        r_cnt   <= 14'd0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 14'd1;
                    end
                end
                default: begin
                    r_cnt   <= 14'd0;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.TX      = r_tx;
    assign bus.READY   = r_ready;
    assign bus.BUSY    = r_busy;
    assign bus.TX_DONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serial.sv
// ============================================================================
//  Module   : tb_uart_tx_serial
//  Brief    : Directed bench; three transmitters in different modes run in parallel.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_serial;

    localparam logic [7:0] c_MODES [3] = '{8'b10110101, 8'b11100011, 8'b01000000};

    logic            clk;
    logic [2:0]      rst_n;
    logic [2:0]      t_load;
    logic [2:0]      t_cts;
    logic [2:0][7:0] t_data;
    logic [2:0]      w_tx, w_ready, w_busy, w_done;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            uart_tx_serial_if bus();
            uart_tx_serial #(.MODOS(c_MODES[g])) u_dut (
                .Clock   (clk),
                .Reset_n (rst_n[g]),
                .bus     (bus)
            );
            assign bus.DATA_IN = t_data[g];
            assign bus.LOAD    = t_load[g];
            assign bus.CTS     = t_cts[g];
            assign w_tx[g]     = bus.TX;
            assign w_ready[g]  = bus.READY;
            assign w_busy[g]   = bus.BUSY;
            assign w_done[g]   = bus.TX_DONE;
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a byte for one edge; afterwards the DUT must be busy with TX still idle-high.
    task automatic accept(input int k, input logic [7:0] data, input string tag);
        t_data[k] = data;
        t_load[k] = 1'b1;
        waitn(1);
        t_load[k] = 1'b0;
        check({tag, "_ready0"}, w_ready[k], 1'b0);
        check({tag, "_busy1"},  w_busy[k],  1'b1);
        check({tag, "_txidle"}, w_tx[k],    1'b1);
    endtask

    // Called one tick after the start edge. exp holds the bits MSB = first sent.
    task automatic check_frame(input int k, input int div, input logic [11:0] exp,
                               input int nbits, input string tag);
        int pos;
        pos = 0;
        check({tag, "_start_edge"}, w_tx[k], 1'b0);
        for (int i = 0; i < nbits; i++) begin
            waitn(i * div + div / 2 - pos);
            pos = i * div + div / 2;
            check($sformatf("%s_bit%0d", tag, i), w_tx[k], exp[nbits - 1 - i]);
        end
        waitn(nbits * div - 1 - pos);
        check({tag, "_last_stop_tx"},   w_tx[k],    1'b1);
        check({tag, "_done_not_early"}, w_done[k],  1'b0);
        check({tag, "_busy_to_end"},    w_busy[k],  1'b1);
        waitn(1);
        check({tag, "_done"},   w_done[k],  1'b1);
        check({tag, "_ready"},  w_ready[k], 1'b1);
        check({tag, "_busy0"},  w_busy[k],  1'b0);
        check({tag, "_tx_hi"},  w_tx[k],    1'b1);
    endtask

    initial begin
        #(120000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n  = 3'b000;
        t_load = 3'b000;
        t_cts  = 3'b101;
        t_data = '0;
        waitn(3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_tx", k),    w_tx[k],    1'b1);
            check($sformatf("rst%0d_ready", k), w_ready[k], 1'b1);
            check($sformatf("rst%0d_busy", k),  w_busy[k],  1'b0);
            check($sformatf("rst%0d_done", k),  w_done[k],  1'b0);
        end
        rst_n = 3'b111;

        fork
            begin : seq_default
                waitn(4);
                accept(0, 8'hA5, "u0a");
                waitn(1);
                check_frame(0, 2604, 12'b0_10100101_0_1, 11, "u0A5");
                // Reload in the TX_DONE cycle: two idle-high clocks, then the next start.
                accept(0, 8'h55, "u0b");
                waitn(1);
                fork
                    check_frame(0, 2604, 12'b0_01010101_0_1, 11, "u055");
                    begin
                        waitn(3000);
                        t_data[0] = 8'h00;
                        t_load[0] = 1'b1;
                        waitn(1);
                        t_load[0] = 1'b0;
                        check("u0_ignored_load_ready", w_ready[0], 1'b0);
                        check("u0_ignored_load_busy",  w_busy[0],  1'b1);
                    end
                join
                waitn(5);
                check("u0_idle_tx",    w_tx[0],    1'b1);
                check("u0_idle_busy",  w_busy[0],  1'b0);
                check("u0_idle_done",  w_done[0],  1'b0);
                check("u0_idle_ready", w_ready[0], 1'b1);
            end

            begin : seq_odd_parity_cts
                waitn(4);
                accept(1, 8'h01, "u1a");
`ifdef UART_TX_CTS_EN
                waitn(20);
                check("u1_cts_hold_tx",   w_tx[1],   1'b1);
                check("u1_cts_hold_busy", w_busy[1], 1'b1);
                t_cts[1] = 1'b1;
                waitn(2);
                check("u1_cts_sync_tx", w_tx[1], 1'b1);
                waitn(1);
`else
                waitn(1);
`endif
                fork
                    check_frame(1, 868, 12'b0_00000001_0_1, 11, "u101");
                    begin
                        waitn(868 * 3);
                        t_cts[1] = 1'b0;
                    end
                join
                t_cts[1] = 1'b1;
                waitn(5);
                accept(1, 8'h03, "u1b");
                waitn(1);
                check_frame(1, 868, 12'b0_00000011_1_1, 11, "u103");
                accept(1, 8'hA5, "u1c");
                waitn(1);
                check("u1_rst_frame_start", w_tx[1], 1'b0);
                waitn(5 * 868 + 434);
                check("u1_pre_rst_d3", w_tx[1], 1'b0);
                rst_n[1] = 1'b0;
                #1;
                check("u1_async_rst_tx",    w_tx[1],    1'b1);
                check("u1_async_rst_ready", w_ready[1], 1'b1);
                check("u1_async_rst_busy",  w_busy[1],  1'b0);
                waitn(3);
                check("u1_in_rst_tx", w_tx[1], 1'b1);
                rst_n[1] = 1'b1;
                waitn(4);
                accept(1, 8'h01, "u1d");
                waitn(1);
                check_frame(1, 868, 12'b0_00000001_0_1, 11, "u1post");
            end

            begin : seq_two_stop
                waitn(4);
                accept(2, 8'hFF, "u2a");
                waitn(1);
                check_frame(2, 5208, 12'b0_11111111_11, 11, "u2FF");
                waitn(1);
                check("u2_done_pulse", w_done[2], 1'b0);
            end
        join

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
